inst_decode_pipe: RTL and testbench

Parametrised, handshaked RV32I instruction decoder: accepts one fetched instruction per cycle with its PC, splits it into register addresses, function fields and a fully sign-extended immediate for every format (I/S/B/U/J), and flags illegal encodings. It sits between fetch and the register-read/ALU issue stage. It adds three things to the fixed-latency decoder:

- valid/ready backpressure;
- a selectable 1- or 2-stage pipeline;
- flush support.

---
 rtl/inst_decode_pipe.sv | 158 +++++++++++++++
 tb/tb_inst_decode_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_pipe.sv
// inst_decode_pipe: handshaked RV32I decoder with a 1- or 2-stage pipeline and flush
// Ports: iClk, iRst (async, active-high); input side iValid/oReady/iInst/iCurPc;
//   iFlush discards everything in flight; output side oValid/iReady with decoded
//   oOpcode, oRs1Addr, oRs2Addr, oRdAddr, oFunct3, oFunct7, oImm, oCurPc, oIllegal.
// Macro INST_DECODE_ILLEGAL_CHECK_EN builds the illegal-encoding check; without it
//   oIllegal is 0 and only unknown opcodes get their fields zeroed.
module inst_decode_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [31:0]     iInst,
  input  logic [XLEN-1:0] iCurPc,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [6:0]      oOpcode,
  output logic [4:0]      oRs1Addr,
  output logic [4:0]      oRs2Addr,
  output logic [4:0]      oRdAddr,
  output logic [2:0]      oFunct3,
  output logic [6:0]      oFunct7,
  output logic [XLEN-1:0] oImm,
  output logic [XLEN-1:0] oCurPc,
  output logic            oIllegal
);
  typedef struct packed {
    logic [6:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            ill;
  } dec_t;
  logic [31:0] di;
  logic [XLEN-1:0] dpc;
  logic dv;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_ld, is_imm, is_jalr, is_st, is_br, is_op, is_u, is_jal, is_sys;
  logic known, bad, ok, ill, shift;
  logic signed [11:0] si, ss;
  logic signed [12:0] sb;
  logic signed [20:0] sj;
  logic signed [31:0] su;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t d, r;
  logic v1, take;
  assign op = di[6:0];
  assign f3 = di[14:12];
  assign f7 = di[31:25];
  assign is_ld   = op == 7'h03;
  assign is_imm  = op == 7'h13;
  assign is_jalr = op == 7'h67;
  assign is_st   = op == 7'h23;
  assign is_br   = op == 7'h63;
  assign is_op   = op == 7'h33;
  assign is_u    = op == 7'h37 || op == 7'h17;
  assign is_jal  = op == 7'h6f;
  assign is_sys  = op == 7'h0f || op == 7'h73;
  assign known = is_ld || is_imm || is_jalr || is_st || is_br || is_op || is_u || is_jal || is_sys;
  assign shift = is_imm && (f3 == 3'd1 || f3 == 3'd5);
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
  logic fbad;
  assign fbad = (is_ld && (f3 == 3'd3 || f3 > 3'd5)) ||
                (is_st && f3 > 3'd2) ||
                (is_br && f3[2:1] == 2'b01) ||
                (is_jalr && f3 != 3'd0) ||
                (is_op && ((f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5))) ||
                (is_imm && ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)));
  assign bad = !known || fbad;
  assign ill = bad;
`else
  assign bad = !known;
  assign ill = 1'b0;
`endif
  assign ok = !bad;
  // Signed locals so the width casts below sign-extend to XLEN
  assign si = di[31:20];
  assign ss = {di[31:25], di[11:7]};
  assign sb = {di[31], di[7], di[30:25], di[11:8], 1'b0};
  assign sj = {di[31], di[19:12], di[20], di[30:21], 1'b0};
  assign su = {di[31:12], 12'b0};
  assign imm_i = XLEN'(si);
  assign imm_s = XLEN'(ss);
  assign imm_b = XLEN'(sb);
  assign imm_j = XLEN'(sj);
  assign imm_u = XLEN'(su);
  always_comb begin
    d.op  = op;
    d.pc  = dpc;
    d.ill = ill;
    d.rs1 = ok && (is_ld || is_imm || is_jalr || is_st || is_br || is_op) ? di[19:15] : 5'd0;
    d.rs2 = ok && (is_st || is_br || is_op) ? di[24:20] : 5'd0;
    d.rd  = ok && !(is_st || is_br) ? di[11:7] : 5'd0;
    d.f3  = ok && !(is_u || is_jal) ? f3 : 3'd0;
    d.f7  = ok && (is_op || shift) ? f7 : 7'd0;
    d.imm = !ok ? '0 :
            (is_ld || is_imm || is_jalr) ? imm_i :
            is_st ? imm_s : is_br ? imm_b : is_u ? imm_u : is_jal ? imm_j : '0;
  end
  // Output stage loads when empty or its content leaves this cycle
  assign take = !v1 || iReady;
  generate
    if (STAGES == 2) begin : g_two
      logic v0;
      logic [31:0] inst0;
      logic [XLEN-1:0] pc0;
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          v0    <= 1'b0;
          inst0 <= '0;
          pc0   <= '0;
        end else begin
          if (oReady && iValid && !iFlush) begin
            inst0 <= iInst;
            pc0   <= iCurPc;
          end
          v0 <= !iFlush && (oReady ? iValid : v0);
        end
      end
      assign oReady = !v0 || take;
      assign di  = inst0;
      assign dpc = pc0;
      assign dv  = v0;
    end else begin : g_one
      assign oReady = take;
      assign di  = iInst;
      assign dpc = iCurPc;
      assign dv  = iValid;
    end
  endgenerate
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      v1 <= 1'b0;
      r  <= '0;
    end else begin
      if (take && dv && !iFlush) r <= d;
      v1 <= !iFlush && (take ? dv : v1);
    end
  end
  assign oValid   = v1;
  assign oOpcode  = r.op;
  assign oRs1Addr = r.rs1;
  assign oRs2Addr = r.rs2;
  assign oRdAddr  = r.rd;
  assign oFunct3  = r.f3;
  assign oFunct7  = r.f7;
  assign oImm     = r.imm;
  assign oCurPc   = r.pc;
  assign oIllegal = r.ill;
endmodule

// File: tb/tb_inst_decode_pipe.sv
// tb_inst_decode_pipe: table, directed and random checks of inst_decode_pipe (STAGES=2)
module tb_inst_decode_pipe;
  logic iClk = 0, iRst = 0, iValid = 0, iFlush = 0, iReady = 0;
  logic [31:0] iInst = 0, iCurPc = 0;
  logic oReady, oValid, oIllegal;
  logic [6:0] oOpcode, oFunct7;
  logic [4:0] oRs1Addr, oRs2Addr, oRdAddr;
  logic [2:0] oFunct3;
  logic [31:0] oImm, oCurPc;
  int errors = 0, checks = 0, tk = 0, acc = 0;
  bit tbl_on = 0;
`ifdef INST_DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } dec_t;
  typedef struct {
    logic [31:0] inst;
    dec_t        exp;
  } vec_t;
  dec_t q[$];
  int age[$];
  logic [31:0] outs[$];
  vec_t tbl[11];
  logic [6:0] ops[11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h0f, 7'h73};

  inst_decode_pipe #(.XLEN(32), .STAGES(2)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iInst(iInst),
    .iCurPc(iCurPc), .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oOpcode(oOpcode), .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr), .oRdAddr(oRdAddr),
    .oFunct3(oFunct3), .oFunct7(oFunct7), .oImm(oImm), .oCurPc(oCurPc), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic dec_t mk(input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic ill);
    return {op, rs1, rs2, rd, f3, f7, imm, 32'h0, ill};
  endfunction

  // Reference decode written straight from the format table
  function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    dec_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit unk, fb;
    f3 = i[14:12];
    f7 = i[31:25];
    unk = 0;
    fb = 0;
    e = '0;
    e.op = i[6:0];
    e.pc = pc;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin
        e.rs1 = i[19:15]; e.rd = i[11:7]; e.f3 = f3;
        e.imm = {{20{i[31]}}, i[31:20]};
        if (i[6:0] == 7'h03) fb = f3 == 3 || f3 > 5;
        if (i[6:0] == 7'h67) fb = f3 != 0;
        if (i[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) begin
          e.f7 = f7;
          fb = (f3 == 1) ? (f7 != 0) : !(f7 inside {7'h00, 7'h20});
        end
      end
      7'h23: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        fb = f3 > 2;
      end
      7'h63: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        fb = f3 == 2 || f3 == 3;
      end
      7'h33: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3; e.f7 = f7;
        fb = !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      end
      7'h37, 7'h17: begin e.rd = i[11:7]; e.imm = {i[31:12], 12'b0}; end
      7'h6f: begin
        e.rd = i[11:7];
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h0f, 7'h73: begin e.rd = i[11:7]; e.f3 = f3; end
      default: unk = 1;
    endcase
    if (unk || (ILL_EN && fb)) begin
      e = '0;
      e.op = i[6:0];
      e.pc = pc;
      e.ill = ILL_EN;
    end
    return e;
  endfunction

  // One clock: check at negedge against the in-order model, then update the model at posedge
  task automatic step();
    dec_t got, e;
    logic xr, xv;
    @(negedge iClk);
    got = {oOpcode, oRs1Addr, oRs2Addr, oRdAddr, oFunct3, oFunct7, oImm, oCurPc, oIllegal};
    xv = q.size() > 0 && age[0] >= 1;
    xr = q.size() < 2 || iReady;
    chk("ready", oReady, xr);
    chk("valid", oValid, xv);
    if (xv) chk("fields", got, q[0]);
    if (tbl_on && oValid && iReady && tk < 11) begin
      e = tbl[tk].exp;
      e.pc = 32'h100 + 32'(tk) * 4;
      chk("table", got, e);
      tk++;
    end
    if (oValid && iReady) outs.push_back(oCurPc);
    if (iValid && oReady) acc++;
    @(posedge iClk);
    if (iFlush) begin
      q.delete();
      age.delete();
    end else begin
      if (xv && iReady) begin
        void'(q.pop_front());
        void'(age.pop_front());
      end
      foreach (age[k]) age[k]++;
      if (iValid && xr) begin
        q.push_back(ref_dec(iInst, iCurPc));
        age.push_back(0);
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] r;
    tbl[0]  = '{32'hFFF10093, mk(7'h13, 2, 0, 1, 0, 0, 32'hFFFFFFFF, 0)};
    tbl[1]  = '{32'hFFDFF0EF, mk(7'h6f, 0, 0, 1, 0, 0, 32'hFFFFFFFC, 0)};
    tbl[2]  = '{32'h00000463, mk(7'h63, 0, 0, 0, 0, 0, 32'h8, 0)};
    tbl[3]  = '{32'h00532623, mk(7'h23, 6, 5, 0, 2, 0, 32'hC, 0)};
    tbl[4]  = '{32'h123450B7, mk(7'h37, 0, 0, 1, 0, 0, 32'h12345000, 0)};
    tbl[5]  = '{32'h402081B3, mk(7'h33, 1, 2, 3, 0, 7'h20, 32'h0, 0)};
    tbl[6]  = '{32'h40335293, mk(7'h13, 6, 0, 5, 5, 7'h20, 32'h403, 0)};
    tbl[7]  = '{32'h300110F3, mk(7'h73, 0, 0, 1, 1, 0, 32'h0, 0)};
    tbl[8]  = '{32'hFF842383, mk(7'h03, 8, 0, 7, 2, 0, 32'hFFFFFFF8, 0)};
    tbl[9]  = '{32'h00000000, mk(7'h00, 0, 0, 0, 0, 0, 32'h0, ILL_EN)};
    tbl[10].inst = 32'h40001033;
    tbl[10].exp  = ILL_EN ? mk(7'h33, 0, 0, 0, 0, 0, 32'h0, 1) : mk(7'h33, 0, 0, 0, 1, 7'h20, 32'h0, 0);
    #1 iRst = 1;
    #2;
    chk("rst_valid", oValid, 1'b0);
    chk("rst_ill", oIllegal, 1'b0);
    chk("rst_fields", {oOpcode, oRs1Addr, oRs2Addr, oRdAddr, oFunct3, oFunct7, oImm, oCurPc}, '0);
    @(posedge iClk);
    @(posedge iClk);
    #1 iRst = 0;
    // table vectors back-to-back with full throughput
    iReady = 1;
    tbl_on = 1;
    for (int k = 0; k < 11; k++) begin
      iValid = 1;
      iInst = tbl[k].inst;
      iCurPc = 32'h100 + 32'(k) * 4;
      step();
    end
    iValid = 0;
    repeat (4) step();
    tbl_on = 0;
    chk("table_count", tk, 11);
    // backpressure: third offer must be refused while both stages hold data
    iReady = 0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      iValid = 1;
      iInst = 32'h00100093 + (32'(k) << 7);
      iCurPc = 32'h300 + 32'(k) * 4;
      step();
    end
    chk("bp_accepted", acc, 2);
    #3 chk("bp_ready", oReady, 1'b0);
    outs.delete();
    iReady = 1;
    for (int k = 0; k < 5 && acc < 3; k++) step();
    iValid = 0;
    repeat (4) step();
    chk("bp_count", outs.size(), 3);
    for (int k = 0; k < 3; k++) chk("bp_order", (k < outs.size()) ? outs[k] : 32'hX, 32'h300 + 32'(k) * 4);
    // flush with two in flight and a simultaneous new input
    iReady = 0;
    for (int k = 0; k < 2; k++) begin
      iValid = 1;
      iInst = 32'h00208113;
      iCurPc = 32'h200 + 32'(k) * 4;
      step();
    end
    iFlush = 1;
    iReady = 1;
    iInst = 32'h00000013;
    iCurPc = 32'hDEAD0;
    step();
    iFlush = 0;
    iValid = 0;
    outs.delete();
    for (int k = 0; k < 2; k++) begin
      #3 chk("flush_valid", oValid, 1'b0);
      step();
    end
    repeat (2) step();
    chk("flush_outputs", outs.size(), 0);
    // asynchronous reset between edges
    iReady = 0;
    for (int k = 0; k < 2; k++) begin
      iValid = 1;
      iInst = 32'h0FF00093;
      iCurPc = 32'h400 + 32'(k) * 4;
      step();
    end
    iValid = 0;
    #2 iRst = 1;
    #1;
    chk("arst_valid", oValid, 1'b0);
    chk("arst_op", oOpcode, 7'h0);
    chk("arst_pc", oCurPc, 32'h0);
    @(posedge iClk);
    #1 iRst = 0;
    q.delete();
    age.delete();
    iReady = 1;
    iValid = 1;
    iInst = 32'hFFF10093;
    iCurPc = 32'h100;
    step();
    iValid = 0;
    repeat (3) step();
    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      iInst = r;
      iCurPc = $urandom();
      iValid = $urandom_range(0, 3) != 0;
      iReady = $urandom_range(0, 3) != 0;
      iFlush = $urandom_range(0, 24) == 0;
      step();
    end
    iFlush = 0;
    iValid = 0;
    iReady = 1;
    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
